// File: rtl/a2d_intf.sv
// ============================================================================
// Module      : a2d_intf
// Description : Two-transaction SPI front end for an ADC128S-style converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a2d_intf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX1  = 2'd1,
    GAP  = 2'd2,
    TX2  = 2'd3
  } state_t;

  localparam logic [4:0] C_DIV_LOAD   = 5'd23;
  localparam logic [4:0] C_DIV_SAMPLE = 5'd17;
  localparam logic [4:0] C_DIV_LAST   = 5'd31;

  state_t      r_state;
  state_t      w_nxt_state;
  logic        w_start;
  logic        w_accept;
  logic        w_finish;
  logic        w_sample;
  logic        w_xfer_end;
  logic [2:0]  w_cmd_chnnl;
  logic [15:0] w_cmd;

  logic        r_ss_n;
  logic [4:0]  r_div;
  logic [3:0]  r_bit_cnt;
  logic        r_last;
  logic [15:0] r_tx;
  logic [15:0] r_rx;
  logic        r_gap_cnt;
  logic        r_done;
  logic [2:0]  r_chnnl;
  logic        r_cmplt;
  logic [11:0] r_res;
  logic        w_unused_rx_hi;

  assign w_sample    = !r_ss_n && (r_div == C_DIV_SAMPLE);
  // End of transaction: all 16 bits sampled and SCLK back at the top of its high phase
  assign w_xfer_end  = !r_ss_n && r_last && (r_div == C_DIV_LAST);
  assign w_cmd_chnnl = (r_state == IDLE) ? chnnl : r_chnnl;
  assign w_cmd       = {2'b00, w_cmd_chnnl, 11'h000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (strt_cnv) begin
          w_nxt_state = TX1;
          w_start     = 1'b1;
          w_accept    = 1'b1;
        end
      end
      TX1: begin
        if (w_xfer_end) w_nxt_state = GAP;
      end
      GAP: begin
        if (r_gap_cnt) begin
          w_nxt_state = TX2;
          w_start     = 1'b1;
        end
      end
      TX2: begin
        if (r_done) begin
          w_nxt_state = IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_n    <= 1'b1;
      r_div     <= 5'd0;
      r_bit_cnt <= 4'd0;
      r_last    <= 1'b0;
      r_tx      <= 16'h0000;
      r_rx      <= 16'h0000;
      r_gap_cnt <= 1'b0;
      r_done    <= 1'b0;
      r_chnnl   <= 3'd0;
    end else begin
      r_done    <= 1'b0;
      r_gap_cnt <= (r_state == GAP);
      if (w_accept) r_chnnl <= chnnl;
      if (w_start) begin
        r_ss_n    <= 1'b0;
        r_div     <= C_DIV_LOAD;
        r_bit_cnt <= 4'd0;
        r_last    <= 1'b0;
        r_tx      <= w_cmd;
      end else if (!r_ss_n) begin
        // Divider freezes at 31 on the final edge so SCLK stays high
        if (w_xfer_end) begin
          r_ss_n <= 1'b1;
          r_done <= (r_state == TX2);
        end else begin
          r_div <= r_div + 5'd1;
        end
        if (w_sample) begin
          r_rx      <= {r_rx[14:0], MISO};
          r_tx      <= {r_tx[14:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd15) r_last <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmplt <= 1'b0;
      r_res   <= 12'h000;
    end else if (w_accept) begin
      r_cmplt <= 1'b0;
    end else if (w_finish) begin
      r_cmplt <= 1'b1;
      r_res   <= r_rx[11:0];
    end
  end

  assign w_unused_rx_hi = ^r_rx[15:12];

  assign cnv_cmplt = r_cmplt;
  assign res       = r_res;
  assign SS_n      = r_ss_n;
  assign SCLK      = r_ss_n | r_div[4];
  assign MOSI      = r_tx[15];

endmodule

`default_nettype wire

// File: tb/tb_a2d_intf.sv
// ============================================================================
// Module      : tb_a2d_intf
// Description : Randomized self-checking bench for a2d_intf with an ADC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a2d_intf;

  logic        clk;
  logic        rst_n;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_checks = 0;
  int n_errors = 0;

  // ADC model / bus monitor state
  logic [15:0] adc_junk;
  logic [15:0] adc_word;
  logic [15:0] cur_word;
  logic [15:0] mosi_word;
  logic        prev_ss;
  logic        prev_sclk;
  int          lo_len, hi_len, falls, rises, bit_idx, txn;
  int          len_q[$];
  int          fall_q[$];
  int          rise_q[$];
  int          gap_q[$];
  logic [15:0] mosi_q[$];

  a2d_intf u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADC drives the next result bit on each SCLK fall; monitor records each SS_n window
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss   = 1'b1;
      prev_sclk = 1'b1;
      lo_len    = 0;
      hi_len    = 0;
      bit_idx   = 0;
      txn       = 0;
      MISO      = 1'b0;
    end else begin
      if (prev_ss && !SS_n) begin
        gap_q.push_back(hi_len);
        txn++;
        cur_word  = (txn % 2 == 1) ? adc_junk : adc_word;
        lo_len    = 0;
        falls     = 0;
        rises     = 0;
        bit_idx   = 0;
        mosi_word = 16'h0000;
      end
      if (!SS_n) begin
        lo_len++;
        if (prev_sclk && !SCLK) begin
          falls++;
          if (bit_idx < 16) MISO = cur_word[15 - bit_idx];
          bit_idx++;
        end
        if (!prev_sclk && SCLK) begin
          rises++;
          mosi_word = {mosi_word[14:0], MOSI};
        end
      end
      if (!prev_ss && SS_n) begin
        len_q.push_back(lo_len);
        fall_q.push_back(falls);
        rise_q.push_back(rises);
        mosi_q.push_back(mosi_word);
        hi_len = 0;
      end
      if (SS_n) hi_len++;
      prev_ss   = SS_n;
      prev_sclk = SCLK;
    end
  end

  task automatic clear_q();
    len_q.delete();
    fall_q.delete();
    rise_q.delete();
    gap_q.delete();
    mosi_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss_n"}, {31'd0, SS_n}, 32'd1);
    check({tag, "_sclk"}, {31'd0, SCLK}, 32'd1);
    check({tag, "_mosi"}, {31'd0, MOSI}, 32'd0);
    check({tag, "_cmplt"}, {31'd0, cnv_cmplt}, 32'd0);
    check({tag, "_res"}, {20'd0, res}, 32'd0);
  endtask

  // Timeline convention: tasks start and end 1 time unit after a rising clk edge
  task automatic run_conv(input logic [2:0] ch, input logic [15:0] w, input bit busy);
    logic [15:0] exp_cmd;
    int n;
    exp_cmd  = {2'b00, ch, 11'h000};
    adc_junk = 16'($urandom);
    adc_word = w;
    clear_q();
    strt_cnv = 1'b1;
    chnnl    = ch;
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    chnnl    = 3'($urandom);
    check("cmplt_drop", {31'd0, cnv_cmplt}, 32'd0);
    n = 0;
    while (!cnv_cmplt && n < 3000) begin
      @(posedge clk); #1;
      n++;
      strt_cnv = 1'b0;
      if (busy && (n == 100 || n == 600)) begin
        strt_cnv = 1'b1;
        chnnl    = 3'($urandom);
      end
    end
    strt_cnv = 1'b0;
    check("latency", n, 32'd1045);
    check("res", {20'd0, res}, {20'd0, w[11:0]});
    check("n_windows", len_q.size(), 32'd2);
    if (len_q.size() == 2 && gap_q.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        check("ss_low_len", len_q[i], 32'd521);
        check("sclk_falls", fall_q[i], 32'd16);
        check("sclk_rises", rise_q[i], 32'd16);
        check("mosi_cmd", {16'd0, mosi_q[i]}, {16'd0, exp_cmd});
      end
      check("ss_gap", gap_q[1], 32'd2);
    end
    if (busy) begin
      repeat (1200) @(posedge clk);
      #1;
      check("busy_no_requeue", len_q.size(), 32'd2);
      check("busy_res_held", {20'd0, res}, {20'd0, w[11:0]});
      check("busy_cmplt_held", {31'd0, cnv_cmplt}, 32'd1);
    end
  endtask

  initial begin
    int unsigned chs[6] = '{1, 0, 4, 2, 3, 7};
    int changes;
    rst_n    = 1'b0;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;
    adc_junk = 16'h0000;
    adc_word = 16'h0000;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    rst_n = 1'b1;
    changes = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0 || cnv_cmplt !== 1'b0 || res !== 12'h000)
        changes++;
    end
    check("idle_static", changes, 32'd0);

    run_conv(3'd4, 16'h0ABC, 1'b0);

    for (int i = 0; i < 6; i++)
      run_conv(3'(chs[i]), 16'(chs[i] * 32'h111), 1'b0);

    repeat (3) run_conv(3'($urandom), 16'($urandom), 1'b0);

    run_conv(3'd5, 16'($urandom), 1'b1);

    run_conv(3'd2, 16'hF123, 1'b0);

    // Reset asserted partway through the second transaction
    adc_junk = 16'($urandom);
    adc_word = 16'h0FED;
    strt_cnv = 1'b1;
    chnnl    = 3'd6;
    @(posedge clk); #1;
    strt_cnv = 1'b0;
    repeat (799) @(posedge clk);
    #1;
    check("pre_rst_ss_low", {31'd0, SS_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    run_conv(3'd3, 16'h4321, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/a2d_intf.md
# a2d_intf

Round-robin A2D interface sitting directly upstream of the IR sensor / PI-math controller. On each `strt_cnv` pulse it runs two back-to-back 16-bit SPI transactions with the ADC128S-style converter. The first transaction selects the requested channel; the second reads back the 12-bit result. It then presents `res[11:0]` with a level `cnv_cmplt` flag that the controller polls before accumulating the reading.

## Interface
- No parameters; SCLK divide ratio fixed at clk/32.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- strt_cnv  input  1  one-cycle request to convert `chnnl`; ignored while busy.
- chnnl  input  3  ADC channel address; latched on accepted `strt_cnv`.
- cnv_cmplt  output  1  high when `res` is valid; held until next accepted `strt_cnv`.
- res  output  12  last conversion result, unsigned; held between conversions.
- SS_n  output  1  ADC slave select, active-low.
- SCLK  output  1  SPI clock; idles high.
- MOSI  output  1  SPI data to ADC.
- MISO  input  1  SPI data from ADC.

## Operation
- Top FSM states:
  - IDLE: `SS_n`=1, `SCLK`=1. On `strt_cnv`: latch `chnnl`, load tx = {2'b00, chnnl, 11'h000}, clear `cnv_cmplt`, go to TX1.
  - TX1: run one SPI transaction; the received word is discarded. Then go to GAP.
  - GAP: `SS_n`=1 for exactly 2 clocks; reload tx with the same command word. Then go to TX2.
  - TX2: run one SPI transaction. On completion: `res` <= rx[11:0], `cnv_cmplt` <= 1, go to IDLE.
- SPI transaction engine:
  - 5-bit divider `sclk_div` is loaded with 23 on the cycle `SS_n` falls and increments every clk. `SCLK` = `sclk_div[4]`.
  - As a result, `SCLK` falls at the 31->0 wrap and rises at the 15->16 step.
  - `MOSI` = tx[15] at all times.
  - Sample/shift point is `sclk_div`==17, two clocks after a rising edge. At that point rx <= {rx[14:0], MISO} and tx <= {tx[14:0], 1'b0}, simultaneously.
  - A 4-bit bit counter counts samples.
  - After the 16th sample, the engine waits until `sclk_div`==31 with `SCLK` still high, then raises `SS_n` on the next edge. The divider is not advanced further; `SCLK` stays high.
  - Exactly 16 `SCLK` falling edges and 16 rising edges occur per transaction.
- Arithmetic: rx/tx are 16-bit shift registers; `res` is rx[11:0] with no sign handling; upper rx bits are ignored.
- `strt_cnv` in any state other than IDLE is ignored and does not restart or queue a conversion.
- `strt_cnv` coincident with completion (last TX2 cycle) is ignored; `cnv_cmplt` still sets.
- `res` is never updated mid-conversion; an aborted conversion leaves `res` unchanged (except by reset).

## Timing
- Reset values: `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `res`=12'h000, FSM=IDLE, divider/bit counter=0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); no partial result is exposed.
- Edge E0 accepts `strt_cnv`. `SS_n` is low from the cycle after E0.
- Each transaction holds `SS_n` low for exactly 521 clocks (9 + 15×32 + 32).
- `cnv_cmplt` and the new `res` appear 521 + 2 + 521 + 1 = 1045 clocks after E0, registered.
- `cnv_cmplt` falls on the clock edge that accepts the next `strt_cnv`. The consumer therefore sees it low on the cycle after pulsing `strt_cnv`.
- SCLK period is 32 clk (640 ns): high 16, low 16.
- MOSI changes only at `sclk_div`==17, i.e. ≥14 clk before the next rising edge.

## Test plan
- Reset: hold `rst_n`=0 -> `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `res`=0. Release with no `strt_cnv` -> outputs stay static for 2000 clk.
- Single conversion: `strt_cnv` with `chnnl`=3'b100; ADC model returns 16'h0ABC in transaction 2.
  - MOSI bits in TX1 = 16'h2000.
  - Two `SS_n` low windows of 521 clk each, separated by 2 clk.
  - `cnv_cmplt` rises 1045 clk after request; `res`=12'hABC.
- Channel sweep: request chnnl 1, 0, 4, 2, 3, 7 in sequence; ADC model returns the channel×0x111 value.
  - Each `res` matches its channel.
  - `cnv_cmplt` drops one clk after each new `strt_cnv`.
- Busy-ignore: extra `strt_cnv` pulses at 100 clk and at 600 clk into a conversion.
  - Exactly one conversion is performed; the latched channel is unchanged.
  - `cnv_cmplt` rises at 1045 clk.
- Upper-bit masking: ADC returns 16'hF123 -> `res`=12'h123.
- Reset mid-TX2: assert `rst_n` low at clk 800.
  - Outputs return to reset values immediately; `res` stays 0.
  - A subsequent request completes normally with correct data.
